fifo_uart_tx: RTL and testbench

Read-side consumer of the synchronous FIFO that serializes bytes onto a UART TX line. It pops one entry whenever the FIFO is non-empty and the line is idle, then shifts it out LSB-first with start/stop framing at a programmable baud rate. It sits between the core's MMIO write FIFO and the board TX pin, and is the draining counterpart to the FIFO's write interface.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;
`else
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd5
  } tx_state_t;
`endif

  localparam int UART_DATA_BITS = 8;

  // Integer truncation: the bit period is rounded down to whole clocks.
  function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int calc_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses o_bit_tick on the last count.
// i_clear restarts the period so the start bit gets a full CLKS_PER_BIT cycles.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last  = (r_cnt == LP_LAST);
  assign o_bit_tick = w_at_last && !i_clear;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one entry per frame, sends 8N1 LSB-first.
// Optional feature macro: UART_TX_PARITY_EN (even parity between data and stop).
//
// state  | meaning
// IDLE   | line high, waiting for fifo_empty == 0
// POP    | one-cycle fifo_rd_en strobe
// LOAD   | capture fifo_dout[7:0], restart bit timer
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (macro builds only)
// STOP   | stop bit (high)
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  tx_busy
);

  localparam int LP_CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int LP_CNT_W        = calc_cnt_width(LP_CLKS_PER_BIT);

  tx_state_t  r_state;
  tx_state_t  w_state_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       w_bit_tick;
  logic       w_clear;
  logic       w_load;
  logic       w_shift;
  logic       w_unused_dout;

  // Upper FIFO bits are not transmitted.
  assign w_unused_dout = ^fifo_dout;

  uart_baud_gen #(
    .CLKS_PER_BIT (LP_CLKS_PER_BIT),
    .CNT_W        (LP_CNT_W)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .o_bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    fifo_rd_en   = 1'b0;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_state_next = POP;
        end
      end
      POP: begin
        fifo_rd_en   = 1'b1;
        w_state_next = LOAD;
      end
      LOAD: begin
        w_clear      = 1'b1;
        w_load       = 1'b1;
        w_state_next = START;
      end
      START: begin
        if (w_bit_tick) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_tick) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^fifo_dout[7:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= fifo_dout[7:0];
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_comb begin
    serial_out = 1'b1;
    case (r_state)
      START:   serial_out = 1'b0;
      DATA:    serial_out = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_out = r_parity;
`endif
      default: serial_out = 1'b1;
    endcase
  end

  assign tx_busy = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, cycle-offset line model, UART receiver.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_fifo_uart_tx;

  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int DW  = 10;
  localparam int CPB = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  localparam int LAST_OFF  = FRAME_CYC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          serial_out;
  logic          tx_busy;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .tx_busy    (tx_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    rx_q[$];
  logic          rxp_q[$];
  int            hi_q[$];
  int            pop_cnt = 0;
  int            last_busy = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame bit k of byte b: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    logic [DW-1:0] w;
    w = DW'($urandom);
    w[7:0] = b;
    q.push_back(w);
    exp_q.push_back(b);
  endtask

  // FIFO model: pop registered on the rd_en edge, data and flag updated just after.
  logic f_pop;
  always @(posedge clk) begin
    f_pop = fifo_rd_en;
    #1;
    if (f_pop === 1'b1) begin
      pop_cnt++;
      if (q.size() == 0) chk("pop_on_empty", 32'd1, 32'd0);
      else fifo_dout = q.pop_front();
    end
    fifo_empty = (q.size() == 0);
  end

  // Line model: m_off is the cycle offset of the current transaction (0 = idle,
  // 1 = pop, 2 = load, 3.. = frame bits of CPB cycles each).
  int         m_off = 0;
  logic [7:0] m_byte = '0;
  logic       s_rst, s_empty, exp_ser;
  int         rx_cnt = -1;
  logic [7:0] rx_b = '0;
  logic       rx_p = 1'b0;
  int         hi_run = 0;
  int         busy_run = 0;

  always @(posedge clk) begin
    s_rst   = rst;
    s_empty = fifo_empty;
    if (s_rst) m_off = 0;
    else if (m_off == 0) begin
      if (!s_empty) begin
        m_off = 1;
        if (exp_q.size() > 0) m_byte = exp_q.pop_front();
      end
    end else if (m_off == LAST_OFF) m_off = 0;
    else m_off++;
    #2;
    if (chk_en) begin
      exp_ser = (m_off >= 3) ? frame_bit(m_byte, (m_off - 3) / CPB) : 1'b1;
      chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, m_off == 1});
      chk("tx_busy", {31'd0, tx_busy}, {31'd0, m_off != 0});
      chk("serial_out", {31'd0, serial_out}, {31'd0, exp_ser});

      if (tx_busy) busy_run++;
      else if (busy_run > 0) begin
        last_busy = busy_run;
        busy_run = 0;
      end

      if (s_rst) rx_cnt = -1;
      else if (rx_cnt < 0) begin
        if (serial_out === 1'b0) begin
          hi_q.push_back(hi_run);
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
          rx_b[rx_cnt / CPB - 1] = serial_out;
        if (NBITS == 11 && rx_cnt == 9 * CPB + CPB / 2) rx_p = serial_out;
        if (rx_cnt == (NBITS - 1) * CPB + CPB / 2) begin
          chk("stop_bit", {31'd0, serial_out}, 32'd1);
          rx_q.push_back(rx_b);
          rxp_q.push_back(rx_p);
          rx_cnt = -1;
        end
      end
      if (serial_out === 1'b1) hi_run++;
      else hi_run = 0;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(q.size() == 0 && fifo_empty && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n < budget}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0;
  int n;
  logic [7:0] snd[$];
  logic [7:0] b;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_serial", {31'd0, serial_out}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    p0 = pop_cnt;
    repeat (50) @(negedge clk);
    chk("rst_no_pop", pop_cnt - p0, 32'd0);

    p0 = pop_cnt;
    repeat (200) @(negedge clk);
    chk("underflow_no_pop", pop_cnt - p0, 32'd0);

    // Single byte
    rx_q.delete();
    p0 = pop_cnt;
    push(8'hA5);
    wait_idle(400);
    chk("single_pops", pop_cnt - p0, 32'd1);
    chk("single_rx_cnt", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("single_rx_byte", {24'd0, rx_q[0]}, 32'h0000_00A5);
    chk("single_busy_len", last_busy, (NBITS == 11) ? 32'd112 : 32'd102);

    // Burst of 8
    rx_q.delete();
    hi_q.delete();
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_idle(2000);
    chk("burst_pops", pop_cnt - p0, 32'd8);
    chk("burst_rx_cnt", rx_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk("burst_rx_byte", {24'd0, rx_q[i]}, i);
    chk("burst_hi_cnt", hi_q.size(), 32'd8);
    for (int i = 1; i < 8 && i < hi_q.size(); i++) begin
      b = 8'(i - 1);
      chk("burst_gap", hi_q[i], (NBITS == 11 && (^b)) ? 32'd23 : 32'd13);
    end
    chk("burst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("burst_line_idle", {31'd0, serial_out}, 32'd1);

    // Reset during data bit 3 of 0x3C
    rx_q.delete();
    p0 = pop_cnt;
    push(8'h3C);
    push(8'h5A);
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_pop_seen", {31'd0, n < 20}, 32'd1);
    repeat (46) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_serial", {31'd0, serial_out}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    rst = 1'b0;
    wait_idle(600);
    chk("midrst_pops", pop_cnt - p0, 32'd2);
    chk("midrst_rx_cnt", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("midrst_rx_byte", {24'd0, rx_q[0]}, 32'h0000_005A);

`ifdef UART_TX_PARITY_EN
    rx_q.delete();
    rxp_q.delete();
    push(8'h07);
    wait_idle(400);
    chk("par07_busy_len", last_busy, 32'd112);
    if (rxp_q.size() > 0) chk("par07_bit", {31'd0, rxp_q[0]}, 32'd1);
    push(8'h03);
    wait_idle(400);
    chk("par_rx_cnt", rxp_q.size(), 32'd2);
    if (rxp_q.size() > 1) chk("par03_bit", {31'd0, rxp_q[1]}, 32'd0);
`endif

    // Randomized traffic with random gaps, including back-to-back pushes
    rx_q.delete();
    snd.delete();
    p0 = pop_cnt;
    for (int k = 0; k < 25; k++) begin
      b = 8'($urandom);
      snd.push_back(b);
      push(b);
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        snd.push_back(b);
        push(b);
      end
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    wait_idle(8000);
    chk("rand_pops", pop_cnt - p0, snd.size());
    chk("rand_rx_cnt", rx_q.size(), snd.size());
    for (int i = 0; i < snd.size() && i < rx_q.size(); i++)
      chk("rand_rx_byte", {24'd0, rx_q[i]}, {24'd0, snd[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
